// File: rtl/blackjack_round_ctrl.sv
// blackjack_round_ctrl: one round of blackjack. It deals cards over a
// req/ack handshake, takes the player's hit/pass keys, runs the dealer's
// draw rule and settles the fixed stake against the credit balance.
module blackjack_round_ctrl #(
  parameter int unsigned BET_W        = 16,
  parameter int unsigned START_CREDIT = 100,
  parameter int unsigned BET_UNIT     = 10,
  parameter int unsigned DEALER_STAND = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             hit,
  input  logic             pass,
  output logic             card_req,
  input  logic             card_ack,
  input  logic [3:0]       card_val,
  output logic [4:0]       player_total,
  output logic [4:0]       dealer_total,
  output logic [BET_W-1:0] bet,
  output logic [BET_W-1:0] credit,
  output logic [1:0]       result,
  output logic             busy
);

  localparam logic [BET_W-1:0] BET_UNIT_C     = BET_W'(BET_UNIT);
  localparam logic [BET_W-1:0] START_CREDIT_C = BET_W'(START_CREDIT);
  localparam logic [4:0]       STAND_C        = 5'(DEALER_STAND);

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_LOSE = 2'b10;
  localparam logic [1:0] RES_PUSH = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEAL,
    S_PLAYER,
    S_DEALER,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic             card_req_q, card_req_d;
  logic [2:0]       deal_cnt_q, deal_cnt_d;
  logic [4:0]       player_q, player_d;
  logic [4:0]       dealer_q, dealer_d;
  logic [BET_W-1:0] bet_q, bet_d;
  logic [BET_W-1:0] credit_q, credit_d;
  logic [1:0]       result_q, result_d;

  logic start_edge;
  logic card_fire;

  // Add one card to a hand. Out-of-range codes count as a ten; an ace is
  // worth 11 only if that keeps the hand at 21 or below, and is never
  // demoted later. The largest reachable total (20 + 11 is impossible,
  // 21 + 10 is the ceiling) fits in five bits, so the sum simply truncates.
  function automatic logic [4:0] add_card(input logic [4:0] total,
                                          input logic [3:0] val);
    logic [4:0] v;
    if (val == 4'd0 || val > 4'd10) begin
      v = 5'd10;
    end else begin
      v = {1'b0, val};
    end
    if (v == 5'd1) begin
      if (total <= 5'd10) begin
        add_card = total + 5'd11;
      end else begin
        add_card = total + 5'd1;
      end
    end else begin
      add_card = total + v;
    end
  endfunction

  assign start_edge = start & ~start_q;
  assign card_fire  = card_req_q & card_ack;

  // Next-state and datapath decisions for the round sequencer.
  always_comb begin
    state_d    = state_q;
    start_d    = start;
    card_req_d = card_req_q;
    deal_cnt_d = deal_cnt_q;
    player_d   = player_q;
    dealer_d   = dealer_q;
    bet_d      = bet_q;
    credit_d   = credit_q;
    result_d   = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A new round needs a fresh start edge and enough credit for the stake;
        // otherwise the last round's outcome stays on display.
        if (start_edge && (credit_q >= BET_UNIT_C)) begin
          player_d   = 5'd0;
          dealer_d   = 5'd0;
          result_d   = RES_NONE;
          bet_d      = BET_UNIT_C;
          credit_d   = credit_q - BET_UNIT_C;
          deal_cnt_d = 3'd0;
          card_req_d = 1'b1;
          state_d    = S_DEAL;
        end
      end

      S_DEAL: begin
        // Even-numbered deal cards go to the player, odd ones to the dealer.
        // After each ack the request rests for one cycle while the total
        // updates, then either re-asserts or hands over to the player.
        if (card_fire) begin
          if (deal_cnt_q[0] == 1'b0) begin
            player_d = add_card(player_q, card_val);
          end else begin
            dealer_d = add_card(dealer_q, card_val);
          end
          deal_cnt_d = deal_cnt_q + 3'd1;
          card_req_d = 1'b0;
        end else if (!card_req_q) begin
          if (deal_cnt_q == 3'd4) begin
            state_d = S_PLAYER;
          end else begin
            card_req_d = 1'b1;
          end
        end
      end

      S_PLAYER: begin
        // Bust and natural 21 are checked on the settled total first. A pass
        // always wins: any outstanding request is dropped, and a card acked
        // in that same cycle is burned rather than added.
        if (player_q > 5'd21) begin
          card_req_d = 1'b0;
          state_d    = S_SETTLE;
        end else if (player_q == 5'd21) begin
          card_req_d = 1'b0;
          state_d    = S_DEALER;
        end else if (pass) begin
          card_req_d = 1'b0;
          state_d    = S_DEALER;
        end else if (card_fire) begin
          player_d   = add_card(player_q, card_val);
          card_req_d = 1'b0;
        end else if (hit && !card_req_q) begin
          card_req_d = 1'b1;
        end
      end

      S_DEALER: begin
        // Dealer draws until reaching the stand threshold; the decision is
        // taken on the idle cycle after each ack, once the total is updated.
        if (card_fire) begin
          dealer_d   = add_card(dealer_q, card_val);
          card_req_d = 1'b0;
        end else if (!card_req_q) begin
          if (dealer_q < STAND_C) begin
            card_req_d = 1'b1;
          end else begin
            state_d = S_SETTLE;
          end
        end
      end

      S_SETTLE: begin
        // A win returns the stake plus an equal payout, a push returns the
        // stake, a loss keeps it. Credit wraps at the register width.
        card_req_d = 1'b0;
        if (player_q > 5'd21) begin
          result_d = RES_LOSE;
        end else if ((dealer_q > 5'd21) || (player_q > dealer_q)) begin
          result_d = RES_WIN;
          credit_d = credit_q + (bet_q << 1);
        end else if (player_q == dealer_q) begin
          result_d = RES_PUSH;
          credit_d = credit_q + bet_q;
        end else begin
          result_d = RES_LOSE;
        end
        state_d = S_DONE;
      end

      default: begin
        state_d    = S_IDLE;
        card_req_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; start_q resets high so a switch that is
  // already on when reset releases cannot launch a round.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b1;
      card_req_q <= 1'b0;
      deal_cnt_q <= 3'd0;
      player_q   <= 5'd0;
      dealer_q   <= 5'd0;
      bet_q      <= '0;
      credit_q   <= START_CREDIT_C;
      result_q   <= RES_NONE;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      card_req_q <= card_req_d;
      deal_cnt_q <= deal_cnt_d;
      player_q   <= player_d;
      dealer_q   <= dealer_d;
      bet_q      <= bet_d;
      credit_q   <= credit_d;
      result_q   <= result_d;
    end
  end

  assign card_req     = card_req_q;
  assign player_total = player_q;
  assign dealer_total = dealer_q;
  assign bet          = bet_q;
  assign credit       = credit_q;
  assign result       = result_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule
